// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC generator and its queues.
package fetch_pkg;

  localparam int XLEN        = 64;
  localparam int EPOCH_W     = 2;
  localparam int INSTR_BYTES = 4;

  // One decoded-side buffer entry: the PC it was fetched from plus the word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  // One outstanding imem request: address and the epoch it was issued under.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [EPOCH_W-1:0] epoch;
  } inflight_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO with a single-cycle flush. The head word is
// visible on data_o whenever the FIFO is non-empty; flush beats a push.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop is still honoured in a flush cycle; it is moot since all is cleared.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop) & ~flush_i;

  // Next-state pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: issues in-order imem requests under a credit limit,
// tags them with an epoch, buffers same-epoch responses for decode and
// discards wrong-path work when the branch unit redirects.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4,
  parameter int              EPOCH_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               req_valid_o,
  output logic [XLEN-1:0]    req_pc_o,
  output logic [EPOCH_W-1:0] req_epoch_o,
  input  logic               req_ready_i,
  input  logic               rsp_valid_i,
  input  logic [31:0]        rsp_instr_i,
  input  logic [EPOCH_W-1:0] rsp_epoch_i,
  output logic               if_valid_o,
  output logic [XLEN-1:0]    if_pc_o,
  output logic [31:0]        if_instr_o,
  input  logic               if_ready_i,
  output logic               misalign_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]    pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               started_q;
  logic               misalign_q, misalign_d;

  logic                    req_fire;
  logic                    rsp_fire;
  logic                    rsp_keep;
  logic                    if_pop;
  logic [CW:0]             used_credits;

  logic [XLEN+EPOCH_W-1:0] inf_head;
  logic [XLEN-1:0]         inf_pc;
  logic [EPOCH_W-1:0]      inf_epoch;
  logic                    inf_empty;
  logic [CW-1:0]           inf_cnt;

  logic [XLEN+31:0]        buf_head;
  logic                    buf_empty;
  logic [CW-1:0]           buf_cnt;

  // Every issued request reserves one buffer slot until it is consumed or
  // dropped, so responses can never overrun the instruction buffer.
  assign used_credits = {1'b0, inf_cnt} + {1'b0, buf_cnt};
  assign req_valid_o  = started_q & (used_credits < (CW+1)'(DEPTH));
  assign req_fire     = req_valid_o & req_ready_i;
  assign req_pc_o     = pc_q;
  assign req_epoch_o  = epoch_q;

  // Responses with nothing outstanding (e.g. leftovers from before a reset)
  // are ignored.
  assign rsp_fire  = rsp_valid_i & ~inf_empty;
  assign inf_pc    = inf_head[XLEN+EPOCH_W-1:EPOCH_W];
  assign inf_epoch = inf_head[EPOCH_W-1:0];
  assign rsp_keep  = rsp_fire & (rsp_epoch_i == epoch_q) & (inf_epoch == epoch_q);

  assign if_valid_o = ~buf_empty;
  assign if_pop     = if_valid_o & if_ready_i;
  assign if_pc_o    = if_valid_o ? buf_head[XLEN+31:32] : '0;
  assign if_instr_o = if_valid_o ? buf_head[31:0]       : '0;
  assign misalign_o = misalign_q;

  // In-flight request queue: never flushed, stale entries drain on return.
  fetch_fifo #(
    .WIDTH (XLEN + EPOCH_W),
    .DEPTH (DEPTH)
  ) u_inflight (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .data_i  ({pc_q, epoch_q}),
    .pop_i   (rsp_fire),
    .data_o  (inf_head),
    .empty_o (inf_empty),
    .count_o (inf_cnt)
  );

  // Instruction buffer towards decode: flushed by a redirect.
  fetch_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (DEPTH)
  ) u_ibuf (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_i),
    .push_i  (rsp_keep),
    .data_i  ({inf_pc, rsp_instr_i}),
    .pop_i   (if_pop),
    .data_o  (buf_head),
    .empty_o (buf_empty),
    .count_o (buf_cnt)
  );

  // Next PC / epoch: redirect overrides sequential advance.
  always_comb begin
    pc_d       = pc_q;
    epoch_d    = epoch_q;
    misalign_d = redirect_i & (redirect_pc_i[1:0] != 2'b00);
    if (redirect_i) begin
      pc_d    = {redirect_pc_i[XLEN-1:2], 2'b00};
      epoch_d = epoch_q + 1'b1;
    end else if (req_fire) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end
  end

  // PC, epoch, start flag and misalign pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      epoch_q    <= '0;
      started_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      started_q  <= 1'b1;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Randomised bench for fetch_pc_gen with a queue-based reference model and
// an in-order imem with 1-4 cycle latency.
module tb_fetch_pc_gen;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        req_valid_o;
  logic [63:0] req_pc_o;
  logic [1:0]  req_epoch_o;
  logic        req_ready_i = 1'b0;
  logic        rsp_valid_i = 1'b0;
  logic [31:0] rsp_instr_i = '0;
  logic [1:0]  rsp_epoch_i = '0;
  logic        if_valid_o;
  logic [63:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_ready_i = 1'b0;
  logic        misalign_o;

  fetch_pc_gen #(.XLEN(64), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .EPOCH_W(2)) dut (
    .clk(clk), .rst(rst),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .req_valid_o(req_valid_o), .req_pc_o(req_pc_o), .req_epoch_o(req_epoch_o),
    .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_instr_i(rsp_instr_i), .rsp_epoch_i(rsp_epoch_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o),
    .if_ready_i(if_ready_i), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [1:0]  epoch;
    logic [31:0] instr;
    int          due;
  } imem_t;

  imem_t        imq[$];
  inflight_t    m_inf[$];
  fetch_entry_t m_buf[$];
  logic [63:0]  hs_log[$];
  logic [63:0]  dec_log[$];
  logic [63:0]  m_pc;
  logic [1:0]   m_epoch;
  logic         m_started;
  logic         m_mis;

  logic        k_ready, k_dec, k_redir, k_stale;
  logic [63:0] k_tgt;
  int          lat_min = 1, lat_max = 4;
  int          cyc = 0;
  int          n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_epoch = 2'd0; m_started = 1'b0; m_mis = 1'b0;
    m_inf.delete(); m_buf.delete(); imq.delete();
  endtask

  task automatic compare_outputs();
    logic exp_rv;
    exp_rv = m_started && ((m_inf.size() + m_buf.size()) < DEPTH);
    chk("req_valid", {63'd0, req_valid_o}, {63'd0, exp_rv});
    chk("req_pc", req_pc_o, m_pc);
    chk("req_epoch", {62'd0, req_epoch_o}, {62'd0, m_epoch});
    chk("misalign", {63'd0, misalign_o}, {63'd0, m_mis});
    chk("if_valid", {63'd0, if_valid_o}, {63'd0, (m_buf.size() != 0)});
    if (m_buf.size() != 0) begin
      chk("if_pc", if_pc_o, m_buf[0].pc);
      chk("if_instr", {32'd0, if_instr_o}, {32'd0, m_buf[0].instr});
    end
  endtask

  // One clock cycle: check outputs, drive inputs, advance model, clock edge.
  task automatic cycle();
    logic       hs, rsp, pop;
    inflight_t  e;
    imem_t      ne;
    compare_outputs();
    rsp_valid_i = 1'b0;
    rsp_instr_i = $urandom();
    rsp_epoch_i = 2'($urandom());
    if (imq.size() > 0 && imq[0].due <= cyc) begin
      rsp_valid_i = 1'b1;
      rsp_instr_i = imq[0].instr;
      rsp_epoch_i = imq[0].epoch;
      void'(imq.pop_front());
    end else if (k_stale) begin
      rsp_valid_i = 1'b1;
    end
    req_ready_i   = k_ready;
    if_ready_i    = k_dec;
    redirect_i    = k_redir;
    redirect_pc_i = k_tgt;

    hs  = m_started && ((m_inf.size() + m_buf.size()) < DEPTH) && k_ready;
    rsp = rsp_valid_i && (m_inf.size() > 0);
    pop = (m_buf.size() > 0) && k_dec;
    e   = '0;
    if (rsp) e = m_inf.pop_front();
    if (pop) begin
      dec_log.push_back(m_buf[0].pc);
      void'(m_buf.pop_front());
    end
    if (k_redir) m_buf.delete();
    else if (rsp && rsp_epoch_i == m_epoch) m_buf.push_back('{pc: e.pc, instr: rsp_instr_i});
    if (hs) begin
      hs_log.push_back(m_pc);
      m_inf.push_back('{pc: m_pc, epoch: m_epoch});
      ne.pc = m_pc; ne.epoch = m_epoch; ne.instr = $urandom();
      ne.due = cyc + $urandom_range(lat_max, lat_min);
      if (imq.size() > 0 && ne.due <= imq[$].due) ne.due = imq[$].due + 1;
      imq.push_back(ne);
    end
    m_mis = k_redir && (k_tgt[1:0] != 2'b00);
    if (k_redir) begin
      m_pc    = {k_tgt[63:2], 2'b00};
      m_epoch = m_epoch + 2'd1;
    end else if (hs) begin
      m_pc = m_pc + 64'd4;
    end
    m_started = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    k_ready = 1'b0; k_dec = 1'b1; k_redir = 1'b0;
    for (int i = 0; i < 60 && (m_inf.size() != 0 || m_buf.size() != 0 || imq.size() != 0); i++)
      cycle();
    n_vec++;
    if (m_inf.size() != 0 || m_buf.size() != 0 || imq.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: actual=%0d pending expected=0", m_inf.size() + m_buf.size());
    end
  endtask

  task automatic chk_log(input string name, input int base, input logic [63:0] exp, input bit use_dec);
    int sz;
    sz = use_dec ? dec_log.size() : hs_log.size();
    if (sz <= base) begin
      n_vec++; n_err++;
      $display("FAIL %s: actual=<none> expected=%h", name, exp);
    end else begin
      chk(name, use_dec ? dec_log[base] : hs_log[base], exp);
    end
  endtask

  initial begin
    int base;
    k_ready = 1'b0; k_dec = 1'b0; k_redir = 1'b0; k_stale = 1'b0; k_tgt = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_outputs();
    chk("rst_if_pc", if_pc_o, 64'h0);
    chk("rst_if_instr", {32'd0, if_instr_o}, 64'h0);
    rst = 1'b0;

    // Sequential fetch with 1-cycle memory.
    lat_min = 1; lat_max = 1; k_ready = 1'b1; k_dec = 1'b1;
    repeat (12) cycle();
    chk_log("p1_req0", 0, 64'h0, 0);
    chk_log("p1_req1", 1, 64'h4, 0);
    chk_log("p1_req2", 2, 64'h8, 0);
    chk_log("p1_dec0", 0, 64'h0, 1);
    chk_log("p1_dec1", 1, 64'h4, 1);
    chk_log("p1_dec2", 2, 64'h8, 1);

    // Credit limit with decode stalled.
    lat_min = 1; lat_max = 4;
    drain();
    k_ready = 1'b1; k_dec = 1'b0;
    base = hs_log.size();
    repeat (12) cycle();
    chk("p2_issued", 64'(hs_log.size() - base), 64'd4);
    chk("p2_req_low", {63'd0, req_valid_o}, 64'd0);
    k_dec = 1'b1; cycle(); k_dec = 1'b0;
    repeat (8) cycle();
    chk("p2_one_more", 64'(hs_log.size() - base), 64'd5);

    // Redirect with two requests in flight.
    drain();
    lat_min = 3; lat_max = 3; k_ready = 1'b1; k_dec = 1'b1;
    repeat (2) cycle();
    k_ready = 1'b0; k_redir = 1'b1; k_tgt = 64'h1000;
    cycle();
    k_redir = 1'b0;
    chk("p3_epoch", {62'd0, req_epoch_o}, 64'd1);
    chk("p3_pc", req_pc_o, 64'h1000);
    base = dec_log.size();
    k_ready = 1'b1;
    repeat (16) cycle();
    chk_log("p3_first_dec", base, 64'h1000, 1);

    // Misaligned redirect target.
    k_redir = 1'b1; k_tgt = 64'h1002;
    cycle();
    k_redir = 1'b0;
    chk("p4_mis_pulse", {63'd0, misalign_o}, 64'd1);
    chk("p4_pc", req_pc_o, 64'h1000);
    chk("p4_epoch", {62'd0, req_epoch_o}, 64'd2);
    cycle();
    chk("p4_mis_end", {63'd0, misalign_o}, 64'd0);

    // Redirect together with pop, request and response.
    lat_min = 1; lat_max = 1; k_ready = 1'b1; k_dec = 1'b1;
    repeat (8) cycle();
    k_redir = 1'b1; k_tgt = 64'h2000;
    cycle();
    k_redir = 1'b0;
    chk("p5_buf_empty", {63'd0, if_valid_o}, 64'd0);
    chk("p5_pc", req_pc_o, 64'h2000);
    repeat (10) cycle();

    // Asynchronous reset with three requests in flight.
    drain();
    lat_min = 4; lat_max = 4; k_ready = 1'b1; k_dec = 1'b0;
    repeat (3) cycle();
    k_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("p6_rst_valid", {63'd0, req_valid_o}, 64'd0);
    chk("p6_rst_pc", req_pc_o, RESET_PC);
    chk("p6_rst_epoch", {62'd0, req_epoch_o}, 64'd0);
    chk("p6_rst_if", {63'd0, if_valid_o}, 64'd0);
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    k_stale = 1'b1; cycle(); k_stale = 1'b0;
    base = hs_log.size();
    lat_min = 1; lat_max = 4; k_ready = 1'b1; k_dec = 1'b1;
    repeat (10) cycle();
    chk_log("p6_restart", base, RESET_PC, 0);

    // Random traffic, including targets near the top of the address space.
    for (int i = 0; i < 500; i++) begin
      k_ready = ($urandom_range(0, 9) < 7);
      k_dec   = ($urandom_range(0, 9) < 6);
      k_redir = ($urandom_range(0, 24) == 0);
      k_tgt   = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                            : {$urandom(), $urandom()};
      cycle();
    end
    k_redir = 1'b0;

    // Five back-to-back redirects wrap the epoch.
    drain();
    for (int i = 0; i < 5; i++) begin
      k_ready = 1'b0; k_dec = 1'b1; k_redir = 1'b1;
      k_tgt = {32'd0, $urandom()};
      cycle();
    end
    k_redir = 1'b0;
    for (int i = 0; i < 150; i++) begin
      k_ready = ($urandom_range(0, 9) < 8);
      k_dec   = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
